alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters: requester 0 is the pipeline EX stage, requester 1 is the multi-cycle mul/div/debug sequencer.
- Arbitrates round-robin and registers the operands that drive the ALU.
- Waits a configurable settle time, captures S/Z/V/N, and returns the result on a valid/ready response channel tagged with the requester id.
- Screens illegal ALUFun codes before issue.

Parameters:
- ALU_LAT, 1, number of cycles the ALU inputs are held before outputs are sampled; legal range 1..15.

Ports:
- iClk  in  1  clock, rising edge.
- iReset  in  1  asynchronous, active-high reset.
- iReqValid0 / iReqValid1  in  1 each  request valid.
- oReqReady0 / oReqReady1  out  1 each  request accepted this cycle.
- iReqA0, iReqB0, iReqA1, iReqB1  in  32 each  operands.
- iReqFun0, iReqFun1  in  6 each  ALUFun code.
- iReqSign0, iReqSign1  in  1 each  signed-operation flag.
- oAluA, oAluB  out  32 each  to ALU iA/iB.
- oAluFun  out  6  to ALU iALUFun.
- oAluSign  out  1  to ALU iSign.
- iAluS  in  32  ALU result.
- iAluZ, iAluV, iAluN  in  1 each  ALU flags.
- oRespValid  out  1  response valid.
- iRespReady  in  1  response consumed.
- oRespId  out  1  granted requester.
- oRespErr  out  1  illegal function code.
- oS  out  32  registered result.
- oZ, oV, oN  out  1 each  registered flags.

Behaviour:
- Legal ALUFun codes: 000000, 000001, 011000, 011110, 010110, 010001, 011010, 100000, 100001, 100011, 110011, 110001, 110101, 111101, 111001, 111111. All other codes are illegal.
- Reset values (asynchronous, iReset=1):
  - state=IDLE, rLast=1.
  - oAluA=0, oAluB=0, oAluFun=0, oAluSign=0.
  - oS=0, oZ=0, oV=0, oN=0.
  - oRespValid=0, oRespId=0, oRespErr=0.
  - oReqReady0=oReqReady1=0.
- Arbitration (IDLE only):
  - Only one valid: that requester is granted.
  - Both valid: grant goes to the requester != rLast.
  - oReqReadyK=1 combinationally in the same cycle (state==IDLE and grantK). At most one ready is high; both are 0 outside IDLE.
- Accept edge (IDLE with a grant):
  - Latch A, B, Fun, Sign into the oAlu* registers; latch oRespId=K; set rLast=K.
  - Fun legal: load cnt=ALU_LAT-1, go to EXEC.
  - Fun illegal: go directly to RESP with oS=0, oZ=1, oV=0, oN=0, oRespErr=1. The ALU output is not sampled.
- EXEC:
  - oAlu* are held stable.
  - cnt!=0: decrement.
  - cnt==0: capture iAluS/Z/V/N into oS/oZ/oV/oN, set oRespErr=0, go to RESP.
- RESP:
  - oRespValid=1; oS/oZ/oV/oN/oRespId/oRespErr are held stable until the handshake completes.
  - iRespReady=1: oRespValid falls on the next edge and state returns to IDLE.
  - No new request is accepted in RESP, even when iRespReady=1 in that same cycle.
- Latency: accept at edge t gives oRespValid high after edge t+ALU_LAT+1. Illegal op: after edge t+1.
- Throughput: one op per ALU_LAT+2 cycles minimum with iRespReady tied high.
- Requester side:
  - Requesters hold valid and payload until they see ready.
  - Deasserting valid before the grant withdraws the request; no state changes.
  - Payload changes while not granted are ignored.
- oAlu* retain the last operation's values while IDLE; they do not toggle on unaccepted requests.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded with no response, and all registers return to reset values.
- rLast updates only on accept, never on response.

Test Plan:
- Single op, ALU_LAT=1: req0 valid A=5, B=3, Fun=000000 at cycle 0 → oReqReady0=1 in cycle 0; oAluA=5/oAluB=3 from cycle 1; oRespValid=1 in cycle 2 with oS=8, oZ=0, oRespId=0, oRespErr=0.
- Contention: both valid from cycle 0 with iRespReady=1 → first grant to 0 (rLast=1 after reset), second to 1, third to 0. Response ids alternate 0,1,0, spaced 3 cycles apart.
- Backpressure: iRespReady=0 for 5 cycles during RESP → oRespValid and oS held constant, both oReqReady stay 0. iRespReady=1 → return to IDLE next edge, pending request granted in the following cycle.
- Illegal code: req1 Fun=000010 → oRespValid one cycle after accept, oRespErr=1, oS=0, oZ=1, oV=0, oN=0, oRespId=1.
- ALU_LAT=3: SUB A=2, B=7, Sign=1 → oAlu* stable 3 cycles; response after edge t+4 with oS=0xFFFFFFFB captured from the ALU.
- Reset in EXEC: assert iReset for 1 cycle → outputs go to reset values immediately (asynchronous). No response ever appears for the aborted op, and the next request is granted to requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// alu_arbiter -- round-robin sharing of one combinational ALU between two requesters,
// with registered operands, a settle counter and a valid/ready response channel. rev 1.0
module alu_arbiter #(
  parameter int ALU_LAT = 1
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iReqValid0,
  input  logic        iReqValid1,
  output logic        oReqReady0,
  output logic        oReqReady1,
  input  logic [31:0] iReqA0,
  input  logic [31:0] iReqB0,
  input  logic [31:0] iReqA1,
  input  logic [31:0] iReqB1,
  input  logic [5:0]  iReqFun0,
  input  logic [5:0]  iReqFun1,
  input  logic        iReqSign0,
  input  logic        iReqSign1,
  output logic [31:0] oAluA,
  output logic [31:0] oAluB,
  output logic [5:0]  oAluFun,
  output logic        oAluSign,
  input  logic [31:0] iAluS,
  input  logic        iAluZ,
  input  logic        iAluV,
  input  logic        iAluN,
  output logic        oRespValid,
  input  logic        iRespReady,
  output logic        oRespId,
  output logic        oRespErr,
  output logic [31:0] oS,
  output logic        oZ,
  output logic        oV,
  output logic        oN
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] c_CNT_INIT = 4'(ALU_LAT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_last;
  logic [3:0]  r_cnt;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [5:0]  r_alu_fun;
  logic        r_alu_sign;
  logic [31:0] r_s;
  logic        r_z;
  logic        r_v;
  logic        r_n;
  logic        r_resp_valid;
  logic        r_resp_id;
  logic        r_resp_err;

  logic        w_grant0;
  logic        w_grant1;
  logic        w_ready0;
  logic        w_ready1;
  logic        w_accept;
  logic        w_sel;
  logic [5:0]  w_fun;
  logic        w_fun_legal;

  // On contention the grant goes to whichever requester was not served last.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (iReqValid0 && iReqValid1) begin
      w_grant0 = r_last;
      w_grant1 = ~r_last;
    end else begin
      w_grant0 = iReqValid0;
      w_grant1 = iReqValid1;
    end
  end

  assign w_ready0 = (r_state == S_IDLE) && w_grant0 && !iReset;
  assign w_ready1 = (r_state == S_IDLE) && w_grant1 && !iReset;
  assign w_accept = w_ready0 || w_ready1;
  assign w_sel    = w_ready1;
  assign w_fun    = w_sel ? iReqFun1 : iReqFun0;

  always_comb begin
    w_fun_legal = 1'b0;
    case (w_fun)
      6'b000000, 6'b000001, 6'b011000, 6'b011110,
      6'b010110, 6'b010001, 6'b011010, 6'b100000,
      6'b100001, 6'b100011, 6'b110011, 6'b110001,
      6'b110101, 6'b111101, 6'b111001, 6'b111111: w_fun_legal = 1'b1;
      default:                                    w_fun_legal = 1'b0;
    endcase
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_fun_legal ? S_EXEC : S_RESP;
      S_EXEC: if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP: if (iRespReady) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_last       <= 1'b1;
      r_cnt        <= 4'd0;
      r_alu_a      <= 32'd0;
      r_alu_b      <= 32'd0;
      r_alu_fun    <= 6'd0;
      r_alu_sign   <= 1'b0;
      r_s          <= 32'd0;
      r_z          <= 1'b0;
      r_v          <= 1'b0;
      r_n          <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_alu_a    <= w_sel ? iReqA1 : iReqA0;
            r_alu_b    <= w_sel ? iReqB1 : iReqB0;
            r_alu_fun  <= w_fun;
            r_alu_sign <= w_sel ? iReqSign1 : iReqSign0;
            r_resp_id  <= w_sel;
            r_last     <= w_sel;
            if (w_fun_legal) begin
              r_cnt <= c_CNT_INIT;
            end else begin
              // Illegal code: answer immediately without sampling the ALU.
              r_s          <= 32'd0;
              r_z          <= 1'b1;
              r_v          <= 1'b0;
              r_n          <= 1'b0;
              r_resp_err   <= 1'b1;
              r_resp_valid <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_s          <= iAluS;
            r_z          <= iAluZ;
            r_v          <= iAluV;
            r_n          <= iAluN;
            r_resp_err   <= 1'b0;
            r_resp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (iRespReady) r_resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign oReqReady0 = w_ready0;
  assign oReqReady1 = w_ready1;
  assign oAluA      = r_alu_a;
  assign oAluB      = r_alu_b;
  assign oAluFun    = r_alu_fun;
  assign oAluSign   = r_alu_sign;
  assign oRespValid = r_resp_valid;
  assign oRespId    = r_resp_id;
  assign oRespErr   = r_resp_err;
  assign oS         = r_s;
  assign oZ         = r_z;
  assign oV         = r_v;
  assign oN         = r_n;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// tb_alu_arbiter -- directed bench for alu_arbiter with ALU_LAT=1 and ALU_LAT=3 instances,
// each driven by a small behavioural ALU.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [5:0] fun);
    case (fun)
      6'b000000: return a + b;
      6'b000001: return a - b;
      6'b011000: return a & b;
      default:   return a ^ b;
    endcase
  endfunction

  // ---------------- ALU_LAT = 1 instance ----------------
  logic        d1_v0 = 0, d1_v1 = 0, d1_s0 = 0, d1_s1 = 0, d1_rr = 0;
  logic [31:0] d1_a0 = 0, d1_b0 = 0, d1_a1 = 0, d1_b1 = 0;
  logic [5:0]  d1_f0 = 0, d1_f1 = 0;
  logic        d1_r0, d1_r1, d1_alu_sign, d1_rv, d1_id, d1_err, d1_z, d1_v, d1_n;
  logic [31:0] d1_alu_a, d1_alu_b, d1_s, d1_alu_s;
  logic [5:0]  d1_alu_fun;

  assign d1_alu_s = alu_model(d1_alu_a, d1_alu_b, d1_alu_fun);

  alu_arbiter #(.ALU_LAT(1)) u_dut1 (
    .iClk(clk), .iReset(rst),
    .iReqValid0(d1_v0), .iReqValid1(d1_v1), .oReqReady0(d1_r0), .oReqReady1(d1_r1),
    .iReqA0(d1_a0), .iReqB0(d1_b0), .iReqA1(d1_a1), .iReqB1(d1_b1),
    .iReqFun0(d1_f0), .iReqFun1(d1_f1), .iReqSign0(d1_s0), .iReqSign1(d1_s1),
    .oAluA(d1_alu_a), .oAluB(d1_alu_b), .oAluFun(d1_alu_fun), .oAluSign(d1_alu_sign),
    .iAluS(d1_alu_s), .iAluZ(d1_alu_s == 32'd0), .iAluV(1'b0), .iAluN(d1_alu_s[31]),
    .oRespValid(d1_rv), .iRespReady(d1_rr), .oRespId(d1_id), .oRespErr(d1_err),
    .oS(d1_s), .oZ(d1_z), .oV(d1_v), .oN(d1_n)
  );

  // ---------------- ALU_LAT = 3 instance ----------------
  logic        d3_v0 = 0, d3_s0 = 0, d3_rr = 0;
  logic [31:0] d3_a0 = 0, d3_b0 = 0;
  logic [5:0]  d3_f0 = 0;
  logic        d3_r0, d3_r1, d3_alu_sign, d3_rv, d3_id, d3_err, d3_z, d3_v, d3_n;
  logic [31:0] d3_alu_a, d3_alu_b, d3_s, d3_alu_s;
  logic [5:0]  d3_alu_fun;

  assign d3_alu_s = alu_model(d3_alu_a, d3_alu_b, d3_alu_fun);

  alu_arbiter #(.ALU_LAT(3)) u_dut3 (
    .iClk(clk), .iReset(rst),
    .iReqValid0(d3_v0), .iReqValid1(1'b0), .oReqReady0(d3_r0), .oReqReady1(d3_r1),
    .iReqA0(d3_a0), .iReqB0(d3_b0), .iReqA1(32'd0), .iReqB1(32'd0),
    .iReqFun0(d3_f0), .iReqFun1(6'd0), .iReqSign0(d3_s0), .iReqSign1(1'b0),
    .oAluA(d3_alu_a), .oAluB(d3_alu_b), .oAluFun(d3_alu_fun), .oAluSign(d3_alu_sign),
    .iAluS(d3_alu_s), .iAluZ(d3_alu_s == 32'd0), .iAluV(1'b0), .iAluN(d3_alu_s[31]),
    .oRespValid(d3_rv), .iRespReady(d3_rr), .oRespId(d3_id), .oRespErr(d3_err),
    .oS(d3_s), .oZ(d3_z), .oV(d3_v), .oN(d3_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; d1_v0 = 1'b1;
    #1;
    n_checks++; if (d1_r0 !== 1'b0) begin n_errors++; $display("FAIL reset_ready0: got %0b want 0", d1_r0); end
    n_checks++; if (d1_rv !== 1'b0) begin n_errors++; $display("FAIL reset_resp_valid: got %0b want 0", d1_rv); end
    n_checks++; if ({d1_alu_a, d1_alu_b, d1_alu_fun, d1_alu_sign} !== 71'd0) begin n_errors++; $display("FAIL reset_alu_regs: got %h/%h/%h/%b want 0", d1_alu_a, d1_alu_b, d1_alu_fun, d1_alu_sign); end
    n_checks++; if ({d1_s, d1_z, d1_v, d1_n, d1_id, d1_err} !== 37'd0) begin n_errors++; $display("FAIL reset_resp_regs: got S=%h Z=%b V=%b N=%b id=%b err=%b want 0", d1_s, d1_z, d1_v, d1_n, d1_id, d1_err); end
    step();
    rst = 1'b0; d1_v0 = 1'b0;
    step();
  endtask

  task automatic test_single_op();
    d1_v0 = 1'b1; d1_a0 = 32'd5; d1_b0 = 32'd3; d1_f0 = 6'b000000;
    #1;
    n_checks++; if ({d1_r0, d1_r1} !== 2'b10) begin n_errors++; $display("FAIL single_ready: got %b want 10", {d1_r0, d1_r1}); end
    step();
    d1_v0 = 1'b0;
    #1;
    n_checks++; if ({d1_alu_a, d1_alu_b} !== {32'd5, 32'd3}) begin n_errors++; $display("FAIL single_operands: got %0d/%0d want 5/3", d1_alu_a, d1_alu_b); end
    n_checks++; if (d1_rv !== 1'b0) begin n_errors++; $display("FAIL single_early_valid: got %b want 0", d1_rv); end
    step();
    n_checks++; if (d1_rv !== 1'b1) begin n_errors++; $display("FAIL single_valid: got %b want 1", d1_rv); end
    n_checks++; if ({d1_s, d1_z, d1_id, d1_err} !== {32'd8, 1'b0, 1'b0, 1'b0}) begin n_errors++; $display("FAIL single_result: got S=%0d Z=%b id=%b err=%b want S=8 Z=0 id=0 err=0", d1_s, d1_z, d1_id, d1_err); end
    d1_rr = 1'b1;
    step();
    n_checks++; if (d1_rv !== 1'b0) begin n_errors++; $display("FAIL single_valid_drop: got %b want 0", d1_rv); end
    d1_rr = 1'b0;
  endtask

  task automatic test_contention();
    logic       er0, er1, ev, eid;
    logic [31:0] es;
    rst = 1'b1; step(); rst = 1'b0; step();
    d1_v0 = 1'b1; d1_a0 = 32'd10; d1_b0 = 32'd4; d1_f0 = 6'b000000;
    d1_v1 = 1'b1; d1_a1 = 32'd10; d1_b1 = 32'd4; d1_f1 = 6'b000001;
    d1_rr = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c == 7) begin d1_v0 = 1'b0; d1_v1 = 1'b0; end
      #1;
      er0 = (c == 0) || (c == 6);
      er1 = (c == 3);
      ev  = (c == 2) || (c == 5) || (c == 8);
      eid = (c == 5);
      es  = (c == 5) ? 32'd6 : 32'd14;
      n_checks++; if ({d1_r0, d1_r1} !== {er0, er1}) begin n_errors++; $display("FAIL contention_ready c%0d: got %b want %b", c, {d1_r0, d1_r1}, {er0, er1}); end
      n_checks++; if (d1_rv !== ev) begin n_errors++; $display("FAIL contention_valid c%0d: got %b want %b", c, d1_rv, ev); end
      if (ev) begin
        n_checks++; if ({d1_id, d1_s} !== {eid, es}) begin n_errors++; $display("FAIL contention_resp c%0d: got id=%b S=%0d want id=%b S=%0d", c, d1_id, d1_s, eid, es); end
      end
      step();
    end
    d1_rr = 1'b0;
  endtask

  task automatic test_backpressure();
    d1_v1 = 1'b1; d1_a1 = 32'd7; d1_b1 = 32'd9; d1_f1 = 6'b000000;
    #1;
    n_checks++; if (d1_r1 !== 1'b1) begin n_errors++; $display("FAIL bp_ready1: got %b want 1", d1_r1); end
    step();
    d1_v1 = 1'b0;
    d1_v0 = 1'b1; d1_a0 = 32'd1; d1_b0 = 32'd1; d1_f0 = 6'b000000;
    #1;
    n_checks++; if (d1_r0 !== 1'b0) begin n_errors++; $display("FAIL bp_exec_ready0: got %b want 0", d1_r0); end
    step();
    for (int c = 2; c < 7; c++) begin
      n_checks++; if ({d1_rv, d1_s, d1_id, d1_r0, d1_r1} !== {1'b1, 32'd16, 1'b1, 2'b00}) begin n_errors++; $display("FAIL bp_hold c%0d: got v=%b S=%0d id=%b rdy=%b%b want v=1 S=16 id=1 rdy=00", c, d1_rv, d1_s, d1_id, d1_r0, d1_r1); end
      step();
    end
    d1_rr = 1'b1;
    #1;
    n_checks++; if ({d1_rv, d1_r0} !== 2'b10) begin n_errors++; $display("FAIL bp_no_accept_in_resp: got v=%b r0=%b want v=1 r0=0", d1_rv, d1_r0); end
    step();
    d1_rr = 1'b0;
    #1;
    n_checks++; if ({d1_rv, d1_r0} !== 2'b01) begin n_errors++; $display("FAIL bp_pending_grant: got v=%b r0=%b want v=0 r0=1", d1_rv, d1_r0); end
    step();
    d1_v0 = 1'b0;
    #1;
    n_checks++; if (d1_alu_a !== 32'd1) begin n_errors++; $display("FAIL bp_second_operand: got %0d want 1", d1_alu_a); end
    step();
    n_checks++; if ({d1_rv, d1_s, d1_id} !== {1'b1, 32'd2, 1'b0}) begin n_errors++; $display("FAIL bp_second_resp: got v=%b S=%0d id=%b want v=1 S=2 id=0", d1_rv, d1_s, d1_id); end
    d1_rr = 1'b1;
    step();
    d1_rr = 1'b0;
  endtask

  task automatic test_illegal();
    d1_v1 = 1'b1; d1_a1 = 32'd3; d1_b1 = 32'd4; d1_f1 = 6'b000010;
    #1;
    n_checks++; if (d1_r1 !== 1'b1) begin n_errors++; $display("FAIL illegal_ready1: got %b want 1", d1_r1); end
    step();
    d1_v1 = 1'b0;
    #1;
    n_checks++; if ({d1_rv, d1_err, d1_id} !== 3'b111) begin n_errors++; $display("FAIL illegal_resp: got v=%b err=%b id=%b want 111", d1_rv, d1_err, d1_id); end
    n_checks++; if ({d1_s, d1_z, d1_v, d1_n} !== {32'd0, 3'b100}) begin n_errors++; $display("FAIL illegal_flags: got S=%h ZVN=%b%b%b want S=0 ZVN=100", d1_s, d1_z, d1_v, d1_n); end
    d1_rr = 1'b1;
    step();
    d1_rr = 1'b0;
    d1_v0 = 1'b1; d1_a0 = 32'd2; d1_b0 = 32'd2; d1_f0 = 6'b000000;
    step();
    d1_v0 = 1'b0;
    step();
    n_checks++; if ({d1_rv, d1_err, d1_s} !== {2'b10, 32'd4}) begin n_errors++; $display("FAIL illegal_err_clears: got v=%b err=%b S=%0d want v=1 err=0 S=4", d1_rv, d1_err, d1_s); end
    d1_rr = 1'b1;
    step();
    d1_rr = 1'b0;
  endtask

  task automatic test_lat3();
    d3_v0 = 1'b1; d3_a0 = 32'd2; d3_b0 = 32'd7; d3_f0 = 6'b000001; d3_s0 = 1'b1;
    #1;
    n_checks++; if (d3_r0 !== 1'b1) begin n_errors++; $display("FAIL lat3_ready0: got %b want 1", d3_r0); end
    step();
    d3_v0 = 1'b0;
    for (int c = 1; c < 4; c++) begin
      #1;
      n_checks++; if ({d3_alu_a, d3_alu_b, d3_alu_fun, d3_alu_sign, d3_rv} !== {32'd2, 32'd7, 6'b000001, 1'b1, 1'b0}) begin n_errors++; $display("FAIL lat3_exec c%0d: got A=%0d B=%0d F=%b sg=%b v=%b want A=2 B=7 F=000001 sg=1 v=0", c, d3_alu_a, d3_alu_b, d3_alu_fun, d3_alu_sign, d3_rv); end
      step();
    end
    n_checks++; if ({d3_rv, d3_s, d3_z, d3_n, d3_err} !== {1'b1, 32'hFFFF_FFFB, 3'b010}) begin n_errors++; $display("FAIL lat3_resp: got v=%b S=%h Z=%b N=%b err=%b want v=1 S=fffffffb Z=0 N=1 err=0", d3_rv, d3_s, d3_z, d3_n, d3_err); end
    d3_rr = 1'b1;
    step();
    n_checks++; if (d3_rv !== 1'b0) begin n_errors++; $display("FAIL lat3_valid_drop: got %b want 0", d3_rv); end
    d3_rr = 1'b0;
  endtask

  task automatic test_reset_in_exec();
    d1_v1 = 1'b1; d1_a1 = 32'd100; d1_b1 = 32'd1; d1_f1 = 6'b000000;
    step();
    d1_v1 = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if ({d1_alu_a, d1_rv, d1_id, d1_s, d1_z} !== {32'd0, 2'b00, 32'd0, 1'b0}) begin n_errors++; $display("FAIL rexec_async: got A=%0d v=%b id=%b S=%0d Z=%b want all 0", d1_alu_a, d1_rv, d1_id, d1_s, d1_z); end
    step();
    rst = 1'b0;
    d1_rr = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (d1_rv !== 1'b0) begin n_errors++; $display("FAIL rexec_no_resp c%0d: got %b want 0", c, d1_rv); end
      step();
    end
    d1_rr = 1'b0;
    d1_v0 = 1'b1; d1_v1 = 1'b1;
    #1;
    n_checks++; if ({d1_r0, d1_r1} !== 2'b10) begin n_errors++; $display("FAIL rexec_grant0: got %b want 10", {d1_r0, d1_r1}); end
    step();
    d1_v0 = 1'b0; d1_v1 = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_illegal();
    test_lat3();
    test_reset_in_exec();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
